trirng_pool: RTL

- Consumer stage directly downstream of trirng. Samples its 18-bit balanced-ternary word every cycle (9 trits, 2 bits each: 00=0, 01=+1, 11=-1).
- Discards a warm-up window after reset and runs a continuous health test on the stream.
- Buffers healthy words in a small first-word-fall-through FIFO that the CPU pops with a valid/take handshake.

---
 rtl/trirng_pool.sv | 137 +++++++++++++
 1 files changed

// File: rtl/trirng_pool.sv
// Health-checked FIFO stage behind trirng: discards a warm-up window, screens the
// stream for illegal trits and stuck runs, and buffers good words for the CPU.
module trirng_pool #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned WARMUP    = 64,
    parameter int unsigned REP_LIMIT = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [17:0]                  i_num,
    input  logic                         i_take,
    output logic [17:0]                  o_num,
    output logic                         o_valid,
    output logic [$clog2(DEPTH+1)-1:0]   o_level,
    output logic                         o_err
);

    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned WW = $clog2(WARMUP + 1);
    localparam int unsigned RW = $clog2(REP_LIMIT + 1);

    typedef enum logic [1:0] {WARM, RUN, FAIL} state_t;

    state_t          state_q, state_d;
    logic [WW-1:0]   warm_q, warm_d;
    logic [RW-1:0]   run_q, run_d;
    logic [17:0]     prev_q, prev_d;
    logic            prev_vld_q, prev_vld_d;
    logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0]   level_q, level_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic [17:0]     mem_q [DEPTH];

    logic            illegal, bad, pop, push;

    always_comb begin
        illegal = 1'b0;
        for (int unsigned k = 0; k < 9; k++) begin
            if (i_num[2*k +: 2] == 2'b10) illegal = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        warm_d     = warm_q;
        run_d      = run_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        level_d    = level_q;
        bad        = 1'b0;
        pop        = 1'b0;
        push       = 1'b0;

        if (state_q != FAIL) begin
            if (prev_vld_q && (i_num == prev_q)) begin
                run_d = (run_q == RW'(REP_LIMIT)) ? run_q : run_q + RW'(1);
            end else begin
                run_d = RW'(1);
            end
            prev_d     = i_num;
            prev_vld_d = 1'b1;
            bad        = illegal || (run_d == RW'(REP_LIMIT));
            pop        = i_take && valid_q;
            // Full is judged on the stored count; a same-edge pop frees the slot.
            push       = (state_q == RUN) && !bad && ((level_q != LW'(DEPTH)) || pop);
        end

        case (state_q)
            WARM: begin
                if (bad) begin
                    state_d = FAIL;
                end else begin
                    warm_d = warm_q + WW'(1);
                    if (warm_q == WW'(WARMUP - 1)) state_d = RUN;
                end
            end
            RUN: begin
                if (bad) begin
                    state_d = FAIL;
                    wr_d    = '0;
                    rd_d    = '0;
                    level_d = '0;
                end else begin
                    if (push) wr_d = wr_q + PW'(1);
                    if (pop)  rd_d = rd_q + PW'(1);
                    case ({push, pop})
                        2'b10:   level_d = level_q + LW'(1);
                        2'b01:   level_d = level_q - LW'(1);
                        default: level_d = level_q;
                    endcase
                end
            end
            default: ;
        endcase

        valid_d = (state_d == RUN) && (level_d != '0);
        err_d   = err_q || (state_d == FAIL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= WARM;
            warm_q     <= '0;
            run_q      <= '0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            wr_q       <= '0;
            rd_q       <= '0;
            level_q    <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            warm_q     <= warm_d;
            run_q      <= run_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            level_q    <= level_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            if (push) mem_q[wr_q] <= i_num;
        end
    end

    assign o_num   = mem_q[rd_q];
    assign o_valid = valid_q;
    assign o_level = level_q;
    assign o_err   = err_q;

endmodule
